// File: rtl/pcie_axi_slice_bridge_pkg.sv
// Shared types and constants for the PCIe AXI register-slice bridge.
package pcie_axi_slice_bridge_pkg;

    typedef enum logic [1:0] {
        Q_RUN,
        Q_DRAIN,
        Q_IDLE
    } quiesce_state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pcie_axi_skid_buf.sv
// Two-entry skid buffer: registered upstream ready, registered output, full throughput.
module pcie_axi_skid_buf
    import pcie_axi_slice_bridge_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             empty
);

    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             in_fire;

    assign in_fire = in_valid & in_ready_q;

    // Ready is only offered while the skid entry is free, so an accepted beat always has a home.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = in_fire;
                skid_data_d  = in_data;
            end else begin
                out_valid_d = in_fire;
                out_data_d  = in_data;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    always_ff @(posedge clk) begin
        out_data_q  <= out_data_d;
        skid_data_q <= skid_data_d;
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign empty     = !out_valid_q && !skid_valid_q;

endmodule

// File: rtl/pcie_axi_slice_bridge.sv
// AXI4 register-slice bridge with outstanding-transaction limits and quiesce/drain handshake.
// Optional completion statistics are built when PCIE_AXI_SLICE_STAT_EN is defined.
module pcie_axi_slice_bridge
    import pcie_axi_slice_bridge_pkg::*;
#(
    parameter int ID_WIDTH        = 6,
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 256,
    parameter int STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_OUTSTANDING = 16,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic [3:0]            s_axi_awcache,
    input  logic [2:0]            s_axi_awprot,
    input  logic [3:0]            s_axi_awqos,
    input  logic [3:0]            s_axi_awregion,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic [3:0]            s_axi_arregion,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic [3:0]            m_axi_awqos,
    output logic [3:0]            m_axi_awregion,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic [3:0]            m_axi_arregion,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  quiesce_req,
    output logic                  quiesce_ack,
    output logic [CNT_W-1:0]      wr_outstanding,
    output logic [CNT_W-1:0]      rd_outstanding,
    output logic                  proto_err
`ifdef PCIE_AXI_SLICE_STAT_EN
    ,
    output logic [31:0]           stat_wr_done,
    output logic [31:0]           stat_rd_done,
    output logic [31:0]           stat_err
`endif
);

    localparam int AX_W = ID_WIDTH + ADDR_WIDTH + 28;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1;
    localparam int B_W  = ID_WIDTH + 2;
    localparam int R_W  = ID_WIDTH + DATA_WIDTH + 3;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    quiesce_state_t   state_q, state_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic             proto_err_q, proto_err_d;
    logic             aw_allow_q, aw_allow_d, ar_allow_q, ar_allow_d;
    logic             aw_skid_ready, ar_skid_ready;
    logic             aw_empty, w_empty, b_empty, ar_empty, r_empty, all_empty;
    logic             aw_hs, ar_hs, b_hs, rl_hs;
    logic [AX_W-1:0]  aw_out, ar_out;
    logic [W_W-1:0]   w_out;
    logic [B_W-1:0]   b_out;
    logic [R_W-1:0]   r_out;

    pcie_axi_skid_buf #(.WIDTH(AX_W)) u_aw (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_axi_awvalid & aw_allow_q), .in_ready(aw_skid_ready),
        .in_data({s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
                  s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion}),
        .out_valid(m_axi_awvalid), .out_ready(m_axi_awready), .out_data(aw_out), .empty(aw_empty)
    );

    pcie_axi_skid_buf #(.WIDTH(W_W)) u_w (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_axi_wvalid), .in_ready(s_axi_wready),
        .in_data({s_axi_wdata, s_axi_wstrb, s_axi_wlast}),
        .out_valid(m_axi_wvalid), .out_ready(m_axi_wready), .out_data(w_out), .empty(w_empty)
    );

    pcie_axi_skid_buf #(.WIDTH(B_W)) u_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_axi_bvalid), .in_ready(m_axi_bready), .in_data({m_axi_bid, m_axi_bresp}),
        .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out), .empty(b_empty)
    );

    pcie_axi_skid_buf #(.WIDTH(AX_W)) u_ar (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_axi_arvalid & ar_allow_q), .in_ready(ar_skid_ready),
        .in_data({s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
                  s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion}),
        .out_valid(m_axi_arvalid), .out_ready(m_axi_arready), .out_data(ar_out), .empty(ar_empty)
    );

    pcie_axi_skid_buf #(.WIDTH(R_W)) u_r (
        .clk(clk), .rst_n(rst_n),
        .in_valid(m_axi_rvalid), .in_ready(m_axi_rready),
        .in_data({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast}),
        .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out), .empty(r_empty)
    );

    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion} = aw_out;
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion} = ar_out;
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast}            = w_out;
    assign {s_axi_bid, s_axi_bresp}                           = b_out;
    assign {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast} = r_out;

    assign s_axi_awready = aw_skid_ready & aw_allow_q;
    assign s_axi_arready = ar_skid_ready & ar_allow_q;
    assign aw_hs         = s_axi_awvalid & s_axi_awready;
    assign ar_hs         = s_axi_arvalid & s_axi_arready;
    assign b_hs          = s_axi_bvalid & s_axi_bready;
    assign rl_hs         = s_axi_rvalid & s_axi_rready & s_axi_rlast;
    assign all_empty     = aw_empty & w_empty & b_empty & ar_empty & r_empty;

    // A completion with nothing outstanding is a protocol violation; the count saturates at zero.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        proto_err_d = proto_err_q;
        if (aw_hs && !b_hs) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end else if (b_hs && !aw_hs) begin
            if (wr_cnt_q == '0) proto_err_d = 1'b1;
            else                wr_cnt_d    = wr_cnt_q - CNT_W'(1);
        end
        if (ar_hs && !rl_hs) begin
            rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end else if (rl_hs && !ar_hs) begin
            if (rd_cnt_q == '0) proto_err_d = 1'b1;
            else                rd_cnt_d    = rd_cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            Q_RUN:   if (quiesce_req) state_d = Q_DRAIN;
            Q_DRAIN: begin
                if (!quiesce_req)
                    state_d = Q_RUN;
                else if (wr_cnt_q == '0 && rd_cnt_q == '0 && all_empty)
                    state_d = Q_IDLE;
            end
            Q_IDLE:  if (!quiesce_req) state_d = Q_RUN;
            default: state_d = Q_RUN;
        endcase
        aw_allow_d = (state_d == Q_RUN) && (wr_cnt_d != MAX_CNT);
        ar_allow_d = (state_d == Q_RUN) && (rd_cnt_d != MAX_CNT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= Q_RUN;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            proto_err_q <= 1'b0;
            aw_allow_q  <= 1'b0;
            ar_allow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            proto_err_q <= proto_err_d;
            aw_allow_q  <= aw_allow_d;
            ar_allow_q  <= ar_allow_d;
        end
    end

    assign quiesce_ack    = (state_q == Q_IDLE);
    assign wr_outstanding = wr_cnt_q;
    assign rd_outstanding = rd_cnt_q;
    assign proto_err      = proto_err_q;

`ifdef PCIE_AXI_SLICE_STAT_EN
    logic [31:0] stat_wr_done_q, stat_wr_done_d;
    logic [31:0] stat_rd_done_q, stat_rd_done_d;
    logic [31:0] stat_err_q, stat_err_d;

    // A B and an erroring R-last in the same cycle both count toward the error total.
    always_comb begin
        stat_wr_done_d = b_hs  ? sat_inc(stat_wr_done_q) : stat_wr_done_q;
        stat_rd_done_d = rl_hs ? sat_inc(stat_rd_done_q) : stat_rd_done_q;
        stat_err_d     = stat_err_q;
        if (b_hs && s_axi_bresp != OKAY)  stat_err_d = sat_inc(stat_err_d);
        if (rl_hs && s_axi_rresp != OKAY) stat_err_d = sat_inc(stat_err_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_wr_done_q <= '0;
            stat_rd_done_q <= '0;
            stat_err_q     <= '0;
        end else begin
            stat_wr_done_q <= stat_wr_done_d;
            stat_rd_done_q <= stat_rd_done_d;
            stat_err_q     <= stat_err_d;
        end
    end

    assign stat_wr_done = stat_wr_done_q;
    assign stat_rd_done = stat_rd_done_q;
    assign stat_err     = stat_err_q;
`endif

endmodule
